// File: rtl/mem_lsu_pkg.sv
// Shared types and constants for the MEM-stage load/store unit.
// Holds the access-size, state and exception encodings, the default bus timeout
// and the misalignment test used by the top level.
package mem_lsu_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } mem_size_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_DRAIN = 2'd2
  } lsu_state_t;

  typedef enum logic [1:0] {
    EXC_NONE = 2'd0,
    EXC_MIS  = 2'd1,
    EXC_BUS  = 2'd2
  } lsu_exc_t;

  localparam int LSU_TIMEOUT_DEF = 255;

  // Halfwords must be 2-byte aligned, words 4-byte aligned.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    return ((size == SZ_H) && off[0]) || ((size == SZ_W) && (off != 2'b00));
  endfunction

endpackage

// File: rtl/mem_lsu_align.sv
// Lane steering for the LSU: byte enables, store-data replication, load extract/extend.
// Latency: purely combinational, zero cycles.
// Backpressure: none; outputs follow inputs. Ports: size/off/sext select, st_data/ld_raw in, be/st_lanes/ld_data out.
module mem_lsu_align
  import mem_lsu_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  off,
  input  logic        sext,
  input  logic [31:0] st_data,
  input  logic [31:0] ld_raw,
  output logic [3:0]  be,
  output logic [31:0] st_lanes,
  output logic [31:0] ld_data
);

  logic [31:0] shifted;

  always_comb begin
    be       = 4'hF;
    st_lanes = st_data;
    // Bring the addressed lane down to bit 0 before extension.
    shifted  = ld_raw >> {off, 3'b000};
    ld_data  = ld_raw;
    case (mem_size_t'(size))
      SZ_B: begin
        be       = 4'b0001 << off;
        st_lanes = {4{st_data[7:0]}};
        ld_data  = {{24{sext & shifted[7]}}, shifted[7:0]};
      end
      SZ_H: begin
        be       = 4'b0011 << off;
        st_lanes = {2{st_data[15:0]}};
        ld_data  = {{16{sext & shifted[15]}}, shifted[15:0]};
      end
      default: begin
        be       = 4'hF;
        st_lanes = st_data;
        ld_data  = ld_raw;
      end
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: turns the latched request into a req/ack bus transaction and builds write-back.
// Latency: best case 2 cycles (issue cycle, then ack cycle); bus outputs registered, stall/wb/except combinational.
// Backpressure: stall_mem holds the upstream register until ack, timeout or flush; req is never retracted.
// Ports: clk/rst, trap, mem_* request from EX/MEM, stall_mem, dbus_* bus, wb_* write-back, lsu_except.
module mem_lsu
  import mem_lsu_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = LSU_TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              trap,
  input  logic              mem_ren,
  input  logic              mem_wen,
  input  logic [1:0]        mem_size,
  input  logic              mem_sext,
  input  logic [DATA_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_gpr_we,
  input  logic [4:0]        mem_gpr_waddr,
  input  logic [DATA_W-1:0] mem_gpr_wdata,
  output logic              stall_mem,
  output logic              dbus_req,
  output logic              dbus_we,
  output logic [DATA_W-1:0] dbus_addr,
  output logic [3:0]        dbus_be,
  output logic [DATA_W-1:0] dbus_wdata,
  input  logic              dbus_ack,
  input  logic [DATA_W-1:0] dbus_rdata,
  output logic              wb_gpr_we,
  output logic [4:0]        wb_gpr_waddr,
  output logic [DATA_W-1:0] wb_gpr_wdata,
  output logic [1:0]        lsu_except
);

  // Value the counter holds during the last cycle a request may wait.
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  lsu_state_t        state_q, state_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] addr_q, addr_d;
  logic [3:0]        be_q, be_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [7:0]        cnt_q, cnt_d;

  logic              any_acc;
  logic              mis;
  logic              acc;
  logic              timeout;
  lsu_exc_t          exc;
  logic [3:0]        al_be;
  logic [DATA_W-1:0] al_wdata;
  logic [DATA_W-1:0] al_ldata;

  mem_lsu_align u_align (
    .size     (mem_size),
    .off      (mem_addr[1:0]),
    .sext     (mem_sext),
    .st_data  (mem_wdata),
    .ld_raw   (dbus_rdata),
    .be       (al_be),
    .st_lanes (al_wdata),
    .ld_data  (al_ldata)
  );

  assign any_acc = mem_ren | mem_wen;
  assign mis     = is_misaligned(mem_size, mem_addr[1:0]);
  assign acc     = any_acc & ~mis & ~trap;
  assign timeout = ~dbus_ack & (cnt_q == TO_LAST);

  always_comb begin
    state_d      = state_q;
    req_d        = req_q;
    we_d         = we_q;
    addr_d       = addr_q;
    be_d         = be_q;
    wdata_d      = wdata_q;
    cnt_d        = cnt_q;
    stall_mem    = 1'b0;
    exc          = EXC_NONE;
    wb_gpr_we    = mem_gpr_we;
    wb_gpr_waddr = mem_gpr_waddr;
    wb_gpr_wdata = mem_gpr_wdata;

    case (state_q)
      ST_IDLE: begin
        if (acc) begin
          stall_mem = 1'b1;
          wb_gpr_we = 1'b0;
          state_d   = ST_BUSY;
          req_d     = 1'b1;
          we_d      = mem_wen;
          addr_d    = {mem_addr[DATA_W-1:2], 2'b00};
          be_d      = al_be;
          wdata_d   = al_wdata;
          cnt_d     = 8'd0;
        end else if (any_acc && mis && !trap) begin
          exc       = EXC_MIS;
          wb_gpr_we = 1'b0;
        end
      end

      ST_BUSY: begin
        if (dbus_ack) begin
          state_d = ST_IDLE;
          req_d   = 1'b0;
          cnt_d   = 8'd0;
          if (trap) begin
            wb_gpr_we = 1'b0;
          end else if (mem_ren) begin
            wb_gpr_wdata = al_ldata;
          end
        end else if (timeout) begin
          state_d   = ST_IDLE;
          req_d     = 1'b0;
          cnt_d     = 8'd0;
          wb_gpr_we = 1'b0;
          if (!trap) begin
            exc = EXC_BUS;
          end
        end else if (trap) begin
          // The slave still owns the request; wait it out in DRAIN.
          state_d   = ST_DRAIN;
          cnt_d     = cnt_q + 8'd1;
          wb_gpr_we = 1'b0;
        end else begin
          stall_mem = 1'b1;
          cnt_d     = cnt_q + 8'd1;
          wb_gpr_we = 1'b0;
        end
      end

      ST_DRAIN: begin
        // Flushed stage is a bubble; a fresh access must wait for IDLE.
        wb_gpr_we = 1'b0;
        stall_mem = any_acc & ~trap;
        if (dbus_ack || timeout) begin
          state_d = ST_IDLE;
          req_d   = 1'b0;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      default: begin
        state_d = ST_IDLE;
        req_d   = 1'b0;
        cnt_d   = 8'd0;
      end
    endcase
  end

  assign lsu_except = exc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      be_q    <= 4'h0;
      wdata_q <= '0;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
    end
  end

  assign dbus_req   = req_q;
  assign dbus_we    = we_q;
  assign dbus_addr  = addr_q;
  assign dbus_be    = be_q;
  assign dbus_wdata = wdata_q;

endmodule

// File: tb/tb_mem_lsu.sv
module tb_mem_lsu;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        trap = 1'b0;
  logic        mem_ren = 1'b0;
  logic        mem_wen = 1'b0;
  logic [1:0]  mem_size = 2'd0;
  logic        mem_sext = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_wdata = '0;
  logic        mem_gpr_we = 1'b0;
  logic [4:0]  mem_gpr_waddr = 5'd0;
  logic [31:0] mem_gpr_wdata = '0;
  logic        stall_mem;
  logic        dbus_req;
  logic        dbus_we;
  logic [31:0] dbus_addr;
  logic [3:0]  dbus_be;
  logic [31:0] dbus_wdata;
  logic        dbus_ack = 1'b0;
  logic [31:0] dbus_rdata = '0;
  logic        wb_gpr_we;
  logic [4:0]  wb_gpr_waddr;
  logic [31:0] wb_gpr_wdata;
  logic [1:0]  lsu_except;

  always #5 clk = ~clk;

  mem_lsu #(.DATA_W(32), .TIMEOUT(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .trap          (trap),
    .mem_ren       (mem_ren),
    .mem_wen       (mem_wen),
    .mem_size      (mem_size),
    .mem_sext      (mem_sext),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_gpr_we    (mem_gpr_we),
    .mem_gpr_waddr (mem_gpr_waddr),
    .mem_gpr_wdata (mem_gpr_wdata),
    .stall_mem     (stall_mem),
    .dbus_req      (dbus_req),
    .dbus_we       (dbus_we),
    .dbus_addr     (dbus_addr),
    .dbus_be       (dbus_be),
    .dbus_wdata    (dbus_wdata),
    .dbus_ack      (dbus_ack),
    .dbus_rdata    (dbus_rdata),
    .wb_gpr_we     (wb_gpr_we),
    .wb_gpr_waddr  (wb_gpr_waddr),
    .wb_gpr_wdata  (wb_gpr_wdata),
    .lsu_except    (lsu_except)
  );

  typedef struct {
    logic        wb_we;
    logic [31:0] wb_wdata;
    logic [1:0]  exc;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, got, exp);
    end
  endtask

  // One access through the slave model: ack in the (wait_n+1)-th cycle req is high.
  task automatic do_access(
    input string       tag,
    input logic        ren,
    input logic        wen,
    input logic [1:0]  size,
    input logic        sext,
    input logic [31:0] addr,
    input logic [31:0] wdata,
    input logic [31:0] rdata,
    input int          wait_n,
    input int          exp_nreq,
    input int          exp_nst,
    input logic        chk_bus,
    input logic [3:0]  exp_be,
    input logic [31:0] exp_baddr,
    input logic [31:0] exp_bwdata,
    input logic        exp_wb_we,
    input logic [31:0] exp_wb_wdata,
    input logic [1:0]  exp_exc
  );
    exp_t e;
    exp_t got_e;
    int   nreq;
    int   nst;
    int   busy_idx;
    logic done;
    logic bus_seen;
    logic [31:0] gdata;
    gdata = 32'h5A5A_0000 | addr;
    @(posedge clk); #1;
    mem_ren       = ren;
    mem_wen       = wen;
    mem_size      = size;
    mem_sext      = sext;
    mem_addr      = addr;
    mem_wdata     = wdata;
    mem_gpr_we    = ren;
    mem_gpr_waddr = 5'd7;
    mem_gpr_wdata = gdata;
    dbus_rdata    = rdata;
    dbus_ack      = 1'b0;
    e.wb_we    = exp_wb_we;
    e.wb_wdata = (exp_wb_we && ren) ? exp_wb_wdata : gdata;
    e.exc      = exp_exc;
    exp_q.push_back(e);
    nreq = 0; nst = 0; busy_idx = 0; done = 1'b0; bus_seen = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      if (dbus_req) begin
        nreq++;
        if (chk_bus && !bus_seen) begin
          bus_seen = 1'b1;
          chk({tag, " dbus_we"}, dbus_we, wen);
          chk({tag, " dbus_be"}, dbus_be, exp_be);
          chk({tag, " dbus_addr"}, dbus_addr, exp_baddr);
          chk({tag, " dbus_wdata"}, dbus_wdata, exp_bwdata);
        end
      end
      if (!stall_mem) begin
        done  = 1'b1;
        got_e = exp_q.pop_front();
        chk({tag, " wb_gpr_we"}, wb_gpr_we, got_e.wb_we);
        chk({tag, " wb_gpr_wdata"}, wb_gpr_wdata, got_e.wb_wdata);
        chk({tag, " wb_gpr_waddr"}, wb_gpr_waddr, 5'd7);
        chk({tag, " lsu_except"}, lsu_except, got_e.exc);
      end else begin
        nst++;
      end
      @(posedge clk); #1;
      if (!done) begin
        if (dbus_req) busy_idx++;
        dbus_ack = (busy_idx == wait_n + 1);
      end
    end
    chk({tag, " completed"}, done, 1'b1);
    exp_q.delete();
    dbus_ack   = 1'b0;
    mem_ren    = 1'b0;
    mem_wen    = 1'b0;
    mem_gpr_we = 1'b0;
    @(negedge clk);
    chk({tag, " req dropped"}, dbus_req, 1'b0);
    chk({tag, " req cycles"}, nreq, exp_nreq);
    chk({tag, " stall cycles"}, nst, exp_nst);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #12;
    @(negedge clk);
    chk("rst req", dbus_req, 1'b0);
    chk("rst we", dbus_we, 1'b0);
    chk("rst be", dbus_be, 4'h0);
    chk("rst addr", dbus_addr, 32'h0);
    chk("rst wdata", dbus_wdata, 32'h0);
    chk("rst stall", stall_mem, 1'b0);
    rst = 1'b1;
    @(negedge clk);

    //        tag     ren  wen  size  sx   addr          wdata         rdata         wt  nreq nst bus be       baddr         bwdata        wbwe wbdata        exc
    do_access("lw",   1,   0,   2'd2, 0,   32'h100,      32'h0,        32'hDEADBEEF, 2,  3,   3,  1,  4'hF,    32'h100,      32'h0,        1,   32'hDEADBEEF, 2'd0);
    do_access("lb",   1,   0,   2'd0, 1,   32'h103,      32'h0,        32'h80FF0000, 0,  1,   1,  1,  4'b1000, 32'h100,      32'h0,        1,   32'hFFFFFF80, 2'd0);
    do_access("lbu",  1,   0,   2'd0, 0,   32'h103,      32'h0,        32'h80FF0000, 1,  2,   2,  1,  4'b1000, 32'h100,      32'h0,        1,   32'h00000080, 2'd0);
    do_access("lh",   1,   0,   2'd1, 1,   32'h102,      32'h0,        32'h80011234, 0,  1,   1,  1,  4'b1100, 32'h100,      32'h0,        1,   32'hFFFF8001, 2'd0);
    do_access("lhu",  1,   0,   2'd1, 0,   32'h204,      32'h0,        32'h1234F00D, 0,  1,   1,  1,  4'b0011, 32'h204,      32'h0,        1,   32'h0000F00D, 2'd0);
    do_access("sh",   0,   1,   2'd1, 0,   32'h202,      32'h1234ABCD, 32'h0,        1,  2,   2,  1,  4'b1100, 32'h200,      32'hABCDABCD, 0,   32'h0,        2'd0);
    do_access("sb",   0,   1,   2'd0, 0,   32'h301,      32'hFFFFFFA5, 32'h0,        0,  1,   1,  1,  4'b0010, 32'h300,      32'hA5A5A5A5, 0,   32'h0,        2'd0);
    do_access("sw",   0,   1,   2'd2, 0,   32'h308,      32'hCAFEF00D, 32'h0,        0,  1,   1,  1,  4'hF,    32'h308,      32'hCAFEF00D, 0,   32'h0,        2'd0);
    do_access("mis lw", 1, 0,   2'd2, 0,   32'h101,      32'h0,        32'h0,        0,  0,   0,  0,  4'h0,    32'h0,        32'h0,        0,   32'h0,        2'd1);
    do_access("mis sh", 0, 1,   2'd1, 0,   32'h203,      32'h0,        32'h0,        0,  0,   0,  0,  4'h0,    32'h0,        32'h0,        0,   32'h0,        2'd1);
    do_access("tmo",  1,   0,   2'd2, 0,   32'h400,      32'h0,        32'h0,        99, 4,   4,  1,  4'hF,    32'h400,      32'h0,        0,   32'h0,        2'd2);

    // Trap one cycle after req: drain until ack, no write-back
    @(posedge clk); #1;
    mem_ren = 1'b1; mem_size = 2'd2; mem_addr = 32'h500; mem_gpr_we = 1'b1; mem_gpr_wdata = 32'h11;
    @(posedge clk); #1;
    trap = 1'b1;
    @(negedge clk);
    chk("trap busy req", dbus_req, 1'b1);
    chk("trap busy wb_we", wb_gpr_we, 1'b0);
    @(posedge clk); #1;
    trap = 1'b0; mem_addr = 32'h504;
    @(negedge clk);
    chk("drain req held", dbus_req, 1'b1);
    chk("drain new acc stall", stall_mem, 1'b1);
    chk("drain wb_we", wb_gpr_we, 1'b0);
    @(posedge clk); #1;
    mem_ren = 1'b0; dbus_ack = 1'b1;
    @(negedge clk);
    chk("drain ack stall", stall_mem, 1'b0);
    chk("drain ack wb_we", wb_gpr_we, 1'b0);
    @(posedge clk); #1;
    dbus_ack = 1'b0;
    @(negedge clk);
    chk("drain exit req", dbus_req, 1'b0);
    chk("idle pass wb_we", wb_gpr_we, 1'b1);

    // Trap coincident with ack: result discarded
    @(posedge clk); #1;
    mem_ren = 1'b1; mem_addr = 32'h600; dbus_rdata = 32'h77;
    @(posedge clk); #1;
    trap = 1'b1; dbus_ack = 1'b1;
    @(negedge clk);
    chk("trap+ack stall", stall_mem, 1'b0);
    chk("trap+ack wb_we", wb_gpr_we, 1'b0);
    @(posedge clk); #1;
    trap = 1'b1; dbus_ack = 1'b0;
    @(negedge clk);
    chk("trap+ack req", dbus_req, 1'b0);
    chk("trap idle no stall", stall_mem, 1'b0);
    @(posedge clk); #1;
    trap = 1'b0; mem_ren = 1'b0;
    @(negedge clk);
    chk("trap idle no issue", dbus_req, 1'b0);

    // Reset mid-access drops req immediately
    @(posedge clk); #1;
    mem_ren = 1'b1; mem_addr = 32'h700;
    @(posedge clk); #1;
    chk("pre-reset req", dbus_req, 1'b1);
    mem_ren = 1'b0; mem_gpr_we = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("async reset req", dbus_req, 1'b0);
    chk("async reset be", dbus_be, 4'h0);
    @(negedge clk);
    rst = 1'b1;

    do_access("post-rst lw", 1, 0, 2'd2, 0, 32'h800, 32'h0, 32'h01020304, 0, 1, 1, 1, 4'hF, 32'h800, 32'h0, 1, 32'h01020304, 2'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
